// File: rtl/anubis_gamma_serial.sv
// anubis_gamma_serial: byte-serial Anubis gamma layer, applies the involutive S-box to a 128-bit state LANES bytes per cycle.
// Build option SBOX_SELFCHECK_EN adds an S(S(x))==x check per lane with a sticky fault that masks o_out_data.
module anubis_gamma_serial #(
   parameter int LANES = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [127:0] i_in_data,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   output logic [127:0] o_out_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic         o_fault
);
   // Byte x of the table lives at bits [8*(255-x) +: 8].
   localparam logic [2047:0] SBOX_TABLE = {
      128'hA7D3E671_D0AC4D79_3AC991FC_1E4754BD,
      128'h8CA57AFB_63B8DDD4_E5B3C5BE_A9880CA2,
      128'h39DF29DA_2BA8CB4C_4B22AA24_4170A6F9,
      128'h5AE2B036_7DE433FF_6020088B_5EAB7F78,
      128'h7C2C57D2_DC6D7E0D_5394C328_27065FAD,
      128'h675C5548_0E52EA42_5B5D3058_51593C4E,
      128'h388A7214_E7C6DE50_8E92D177_93459ACE,
      128'h2D0362B6_B9BF966B_3F0712AE_4034463E,
      128'hDBCFECCC_C1A1C0D6_1DF4613B_10D868A0,
      128'hB10A696C_49FA76C4_9E9B6E99_C2B798BC,
      128'h8F851FB4_F8112E00_251C2A3D_054F7BB2,
      128'h3290AF19_A3F7739D_1574EECA_9F0F1B75,
      128'h86849C4A_971A65F6_ED09BB26_83EB6F81,
      128'h046A4301_17E187F5_8DE32380_44166621,
      128'hFED531D9_35180264_F2F156CD_82C8BAF0,
      128'hEFE9E8FD_89D7C7B5_A42F9513_0BF3E037
   };
   localparam logic [3:0] LAST_IDX = 4'(16 - LANES);
   localparam logic [3:0] IDX_STEP = 4'(LANES);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("anubis_gamma_serial: LANES must be 1, 2, 4, 8 or 16");
   end

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t             r_state;
   logic [3:0]         r_idx;
   logic [127:0]       r_data;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [127:0]       r_out_data;
   logic [8*LANES-1:0] w_lane_in;
   logic [8*LANES-1:0] w_lane_out;
   logic [127:0]       w_next_data;

   // Byte (r_idx + l) sits at bit offset 8*(15 - pos) = {~pos, 3'b000}.
   always_comb begin
      w_lane_in   = '0;
      w_lane_out  = '0;
      w_next_data = r_data;
      for (int l = 0; l < LANES; l++) begin
         w_lane_in[8*l +: 8]  = r_data[{~(r_idx + 4'(l)), 3'b000} +: 8];
         w_lane_out[8*l +: 8] = sbox(w_lane_in[8*l +: 8]);
         w_next_data[{~(r_idx + 4'(l)), 3'b000} +: 8] = w_lane_out[8*l +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= 4'd0;
         r_data      <= 128'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 128'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid && r_in_ready) begin
                  r_data     <= i_in_data;
                  r_idx      <= 4'd0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_RUN;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               r_data <= w_next_data;
               if (r_idx == LAST_IDX) begin
                  r_idx       <= 4'd0;
                  r_out_data  <= w_next_data;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_idx <= r_idx + IDX_STEP;
               end
            end
            ST_DONE: begin
               // Reopen the input in the same edge so IDLE offers in_ready immediately.
               if (r_out_valid && i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_data  <= 128'd0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_idx       <= 4'd0;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_out_data  <= 128'd0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;

`ifdef SBOX_SELFCHECK_EN
   logic [8*LANES-1:0] w_chk_data;
   logic               w_chk_err;
   logic               r_fault;

   // Independent second lookup per lane; an involution must map back to the lane input.
   always_comb begin
      w_chk_data = '0;
      for (int l = 0; l < LANES; l++) begin
         w_chk_data[8*l +: 8] = sbox(w_lane_out[8*l +: 8]);
      end
   end

   assign w_chk_err = (w_chk_data != w_lane_in);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_fault <= 1'b0;
      end else if ((r_state == ST_RUN) && w_chk_err) begin
         r_fault <= 1'b1;
      end else begin
         r_fault <= r_fault;
      end
   end

   assign o_fault    = r_fault;
   assign o_out_data = r_fault ? 128'd0 : r_out_data;
`else
   assign o_fault    = 1'b0;
   assign o_out_data = r_out_data;
`endif

endmodule

// File: tb/tb_anubis_gamma_serial.sv
// Directed bench for anubis_gamma_serial: LANES=1 instance for latency/stall/reset cases, LANES=16 instance for random words.
// Expected values come from hand-computed vectors and a bench-side S-box table.
module tb_anubis_gamma_serial;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] a_in_data;
   logic         a_in_valid;
   logic         a_in_ready;
   logic [127:0] a_out_data;
   logic         a_out_valid;
   logic         a_out_ready;
   logic         a_fault;
   logic [127:0] b_in_data;
   logic         b_in_valid;
   logic         b_in_ready;
   logic [127:0] b_out_data;
   logic         b_out_valid;
   logic         b_out_ready;
   logic         b_fault;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [7:0] sb [256] = '{
      8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
      8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
      8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
      8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
      8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
      8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
      8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
      8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
      8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
      8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
      8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
      8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
      8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
      8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
      8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
      8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
   };

   anubis_gamma_serial #(.LANES(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_data(a_in_data), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
      .o_out_data(a_out_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
      .o_fault(a_fault)
   );

   anubis_gamma_serial #(.LANES(16)) u_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_data(b_in_data), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
      .o_out_data(b_out_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
      .o_fault(b_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] gamma_ref(input logic [127:0] x);
      logic [127:0] y;
      y = 128'd0;
      for (int k = 0; k < 16; k++) y[8*k +: 8] = sb[x[8*k +: 8]];
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input logic [127:0] d);
      int g;
      g = 0;
      while (a_in_ready !== 1'b1 && g < 20) begin
         tick();
         g++;
      end
      a_in_data  = d;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic wait_a(output int cyc);
      cyc = 0;
      while (a_out_valid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic drain_a();
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           cyc;
      int           seen;
      int           stall;
      int           g;
      logic [127:0] d;

      rst_n = 1'b0;
      a_in_data = 128'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_data = 128'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", {127'd0, a_in_ready}, 128'd0);
      chk("rst_out_valid", {127'd0, a_out_valid}, 128'd0);
      chk("rst_out_data", a_out_data, 128'd0);
      chk("rst_fault", {126'd0, a_fault, b_fault}, 128'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {126'd0, a_in_ready, b_in_ready}, 128'd3);

      // T1: all-zero word, 16-cycle latency
      send_a(128'd0);
      chk("t1_in_ready_run", {127'd0, a_in_ready}, 128'd0);
      wait_a(cyc);
      chk("t1_latency", 128'(cyc), 128'd16);
      chk("t1_data", a_out_data, {16{8'hA7}});
      drain_a();
      chk("t1_valid_drop", {127'd0, a_out_valid}, 128'd0);
      chk("t1_ready_back", {127'd0, a_in_ready}, 128'd1);
      chk("t1_data_cleared", a_out_data, 128'd0);

      // T2 + T3: known vector, stalled output, ignored input
      send_a(128'h00010203_04050607_08090A0B_0C0D0E0F);
      wait_a(cyc);
      chk("t2_latency", 128'(cyc), 128'd16);
      chk("t2_data", a_out_data, 128'hA7D3E671_D0AC4D79_3AC991FC_1E4754BD);
      a_in_data  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      a_in_valid = 1'b1;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t3_stall_data", a_out_data, 128'hA7D3E671_D0AC4D79_3AC991FC_1E4754BD);
         chk("t3_stall_valid", {127'd0, a_out_valid}, 128'd1);
         chk("t3_stall_in_ready", {127'd0, a_in_ready}, 128'd0);
      end
      a_in_valid = 1'b0;
      drain_a();
      seen = 0;
      repeat (20) begin
         tick();
         if (a_out_valid === 1'b1) seen++;
      end
      chk("t3_nothing_queued", 128'(seen), 128'd0);
      send_a(128'hA7D3E671_D0AC4D79_3AC991FC_1E4754BD);
      wait_a(cyc);
      chk("t2_roundtrip", a_out_data, 128'h00010203_04050607_08090A0B_0C0D0E0F);
      drain_a();

      // Anchor bytes: FF->37, EF->F0, 0F->BD, 01->D3, 00->A7, A7->00
      send_a(128'hFFEF0F01_00A737F0_BDD3A700_01020304);
      wait_a(cyc);
      chk("anchor_data", a_out_data, 128'h37F0BDD3_A700FFEF_0F0100A7_D3E671D0);
      drain_a();

      // T4: reset in RUN cycle 7 abandons the word
      send_a(128'h00010203_04050607_08090A0B_0C0D0E0F);
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      chk("t4_rst_out_valid", {127'd0, a_out_valid}, 128'd0);
      chk("t4_rst_in_ready", {127'd0, a_in_ready}, 128'd0);
      chk("t4_rst_out_data", a_out_data, 128'd0);
      rst_n = 1'b1;
      tick();
      chk("t4_ready_after_rst", {127'd0, a_in_ready}, 128'd1);
      seen = 0;
      repeat (20) begin
         tick();
         if (a_out_valid === 1'b1) seen++;
      end
      chk("t4_no_output", 128'(seen), 128'd0);
      send_a(128'hFFEF0F01_00A737F0_BDD3A700_01020304);
      wait_a(cyc);
      chk("t4_latency", 128'(cyc), 128'd16);
      chk("t4_data", a_out_data, 128'h37F0BDD3_A700FFEF_0F0100A7_D3E671D0);
      drain_a();

      // T5: LANES=16, random words, random output stalls
      for (int w = 0; w < 100; w++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         g = 0;
         while (b_in_ready !== 1'b1 && g < 10) begin
            tick();
            g++;
         end
         b_in_data  = d;
         b_in_valid = 1'b1;
         tick();
         b_in_valid = 1'b0;
         chk("t5_not_yet_valid", {127'd0, b_out_valid}, 128'd0);
         tick();
         chk("t5_latency1", {127'd0, b_out_valid}, 128'd1);
         stall = $urandom_range(0, 3);
         repeat (stall) tick();
         chk("t5_data", b_out_data, gamma_ref(d));
         b_out_ready = 1'b1;
         tick();
         b_out_ready = 1'b0;
      end

`ifdef SBOX_SELFCHECK_EN
      // T6: corrupted check lookup raises a sticky fault and masks the output
      send_a(128'd0);
      tick();
      force u_a.w_chk_data = 8'h5A;
      tick();
      release u_a.w_chk_data;
      chk("t6_fault_set", {127'd0, a_fault}, 128'd1);
      wait_a(cyc);
      chk("t6_data_masked", a_out_data, 128'd0);
      drain_a();
      send_a(128'h00010203_04050607_08090A0B_0C0D0E0F);
      wait_a(cyc);
      chk("t6_fault_sticky", {127'd0, a_fault}, 128'd1);
      chk("t6_still_masked", a_out_data, 128'd0);
      drain_a();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_fault_cleared", {127'd0, a_fault}, 128'd0);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
